// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 post-adder/accumulator stage:
// datapath width, OPMODE bit positions and X/Z operand select codes.
package dsp48a1_pkg;

  localparam int P_W = 48;

  localparam int OPM_POSTSUB = 7;
  localparam int OPM_X_HI    = 1;
  localparam int OPM_X_LO    = 0;
  localparam int OPM_Z_HI    = 3;
  localparam int OPM_Z_LO    = 2;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } xsel_t;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } zsel_t;

endpackage

// File: rtl/dsp_post_adder_acc_if.sv
// Operand, control and result bundle of the post-adder stage.
// The slave side is the DSP stage; the master side feeds it operands.
interface dsp_post_adder_acc_if;
  import dsp48a1_pkg::*;

  logic           CEP;
  logic           CECARRYOUT;
  logic [7:0]     OPMODE;
  logic [35:0]    M;
  logic [17:0]    D;
  logic [17:0]    A;
  logic [17:0]    B;
  logic [P_W-1:0] C;
  logic [P_W-1:0] PCIN;
  logic           CIN;
  logic [P_W-1:0] P;
  logic [P_W-1:0] PCOUT;
  logic           CARRYOUT;
  logic           CARRYOUTF;

  modport master (
    output CEP, CECARRYOUT, OPMODE, M, D, A, B, C, PCIN, CIN,
    input  P, PCOUT, CARRYOUT, CARRYOUTF
  );

  modport slave (
    input  CEP, CECARRYOUT, OPMODE, M, D, A, B, C, PCIN, CIN,
    output P, PCOUT, CARRYOUT, CARRYOUTF
  );

endinterface

// File: rtl/dsp_postadd_core.sv
// Combinational X/Z operand selection and 49-bit add/subtract.
// cout is the carry on add and the borrow on subtract.
module dsp_postadd_core
  import dsp48a1_pkg::*;
(
  input  logic [7:0]     opmode,
  input  logic [35:0]    m,
  input  logic [11:0]    d_lo,
  input  logic [17:0]    a,
  input  logic [17:0]    b,
  input  logic [P_W-1:0] c,
  input  logic [P_W-1:0] pcin,
  input  logic           cin,
  input  logic [P_W-1:0] p_fb,
  output logic [P_W-1:0] post,
  output logic           cout
);

  logic [P_W-1:0] x_op;
  logic [P_W-1:0] z_op;
  logic [P_W:0]   sum;
  xsel_t          xsel;
  zsel_t          zsel;

  assign xsel = xsel_t'(opmode[OPM_X_HI:OPM_X_LO]);
  assign zsel = zsel_t'(opmode[OPM_Z_HI:OPM_Z_LO]);

  always_comb begin
    x_op = '0;
    case (xsel)
      X_ZERO:  x_op = '0;
      X_M:     x_op = {12'b0, m};
      X_P:     x_op = p_fb;
      X_DAB:   x_op = {d_lo, a, b};
      default: x_op = '0;
    endcase
  end

  always_comb begin
    z_op = '0;
    case (zsel)
      Z_ZERO:  z_op = '0;
      Z_PCIN:  z_op = pcin;
      Z_P:     z_op = p_fb;
      Z_C:     z_op = c;
      default: z_op = '0;
    endcase
  end

  // Carry-in joins the X side so subtract computes Z - (X + CIN).
  always_comb begin
    if (opmode[OPM_POSTSUB])
      sum = {1'b0, z_op} - ({1'b0, x_op} + {{P_W{1'b0}}, cin});
    else
      sum = {1'b0, z_op} + {1'b0, x_op} + {{P_W{1'b0}}, cin};
  end

  assign post = sum[P_W-1:0];
  assign cout = sum[P_W];

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: P and carry-out registers with async
// reset, optional register bypass, and P feedback for multiply-accumulate.
module dsp_post_adder_acc
  import dsp48a1_pkg::*;
#(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int P_WIDTH     = 48
) (
  input logic                clk,
  input logic                rst,
  dsp_post_adder_acc_if.slave bus
);

  logic [P_WIDTH-1:0] p_q;
  logic               co_q;
  logic [P_W-1:0]     post;
  logic               cout;
  logic               unused_bits;

  assign unused_bits = ^{bus.OPMODE[6:4], bus.D[17:12]};

  // Feedback always comes from p_q, so PREG=0 has no combinational loop.
  dsp_postadd_core u_core (
    .opmode (bus.OPMODE),
    .m      (bus.M),
    .d_lo   (bus.D[11:0]),
    .a      (bus.A),
    .b      (bus.B),
    .c      (bus.C),
    .pcin   (bus.PCIN),
    .cin    (bus.CIN),
    .p_fb   (p_q),
    .post   (post),
    .cout   (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q  <= '0;
      co_q <= 1'b0;
    end else begin
      if (bus.CEP)
        p_q <= post;
      if (bus.CECARRYOUT)
        co_q <= cout;
    end
  end

  generate
    if (PREG != 0) begin : g_preg
      assign bus.P = p_q;
    end else begin : g_pcomb
      assign bus.P = post;
    end

    if (CARRYOUTREG != 0) begin : g_coreg
      assign bus.CARRYOUT = co_q;
    end else begin : g_cocomb
      assign bus.CARRYOUT = cout;
    end
  endgenerate

  assign bus.PCOUT     = bus.P;
  assign bus.CARRYOUTF = bus.CARRYOUT;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Bench: a registered (PREG=1) and a bypassed (PREG=0) instance share stimulus
// and are compared against an arithmetic reference model of the accumulator.
module tb_dsp_post_adder_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_post_adder_acc_if ifr ();
  dsp_post_adder_acc_if ifc ();

  assign ifc.CEP        = ifr.CEP;
  assign ifc.CECARRYOUT = ifr.CECARRYOUT;
  assign ifc.OPMODE     = ifr.OPMODE;
  assign ifc.M          = ifr.M;
  assign ifc.D          = ifr.D;
  assign ifc.A          = ifr.A;
  assign ifc.B          = ifr.B;
  assign ifc.C          = ifr.C;
  assign ifc.PCIN       = ifr.PCIN;
  assign ifc.CIN        = ifr.CIN;

  dsp_post_adder_acc #(.PREG(1), .CARRYOUTREG(1), .P_WIDTH(48)) dut_r (
    .clk (clk), .rst (rst), .bus (ifr.slave)
  );
  dsp_post_adder_acc #(.PREG(0), .CARRYOUTREG(0), .P_WIDTH(48)) dut_c (
    .clk (clk), .rst (rst), .bus (ifc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: accumulator and carry flag as the specification defines them.
  logic [47:0] mp  = '0;
  logic        mco = 1'b0;
  logic [47:0] e6;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Z plus/minus (X + CIN) computed as 49-bit unsigned arithmetic.
  function automatic logic [48:0] ref_sum(input logic [47:0] acc);
    logic [48:0] xv, zv, cv;
    case (ifr.OPMODE[1:0])
      2'd0:    xv = '0;
      2'd1:    xv = 49'(ifr.M);
      2'd2:    xv = 49'(acc);
      default: xv = 49'({ifr.D[11:0], ifr.A, ifr.B});
    endcase
    case (ifr.OPMODE[3:2])
      2'd0:    zv = '0;
      2'd1:    zv = 49'(ifr.PCIN);
      2'd2:    zv = 49'(acc);
      default: zv = 49'(ifr.C);
    endcase
    cv = 49'(ifr.CIN);
    return ifr.OPMODE[7] ? (zv - (xv + cv)) : (zv + xv + cv);
  endfunction

  // Inputs are already applied; check bypass outputs, clock once, check registers.
  task automatic cycle(input string tag);
    logic [48:0] s;
    #1;
    s = ref_sum(mp);
    chk({tag, ".comb_p"},  64'(ifc.P), 64'(s[47:0]));
    chk({tag, ".comb_co"}, 64'(ifc.CARRYOUT), 64'(s[48]));
    @(posedge clk);
    if (!rst) begin
      if (ifr.CEP)        mp  = s[47:0];
      if (ifr.CECARRYOUT) mco = s[48];
    end
    #1;
    chk({tag, ".reg_p"},      64'(ifr.P), 64'(mp));
    chk({tag, ".reg_pcout"},  64'(ifr.PCOUT), 64'(mp));
    chk({tag, ".reg_co"},     64'(ifr.CARRYOUT), 64'(mco));
    chk({tag, ".reg_cof"},    64'(ifr.CARRYOUTF), 64'(mco));
    chk({tag, ".comb_pcout"}, 64'(ifc.PCOUT), 64'(ifc.P));
    $display("txn %s opmode=%h P=%h CO=%b", tag, ifr.OPMODE, ifr.P, ifr.CARRYOUT);
  endtask

  // Raise rst between edges, check the immediate clear, hold for n edges.
  task automatic do_reset(input string tag, input int n);
    rst = 1'b1;
    #1;
    mp  = '0;
    mco = 1'b0;
    chk({tag, ".rst_p"},  64'(ifr.P), 64'd0);
    chk({tag, ".rst_co"}, 64'(ifr.CARRYOUT), 64'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk({tag, ".rst_hold_p"},  64'(ifr.P), 64'd0);
      chk({tag, ".rst_hold_co"}, 64'(ifr.CARRYOUT), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("txn %s reset released", tag);
  endtask

  task automatic set_ops(input logic [7:0] op, input logic [47:0] c, input logic [35:0] m,
                         input logic cin);
    ifr.OPMODE = op;
    ifr.C      = c;
    ifr.M      = m;
    ifr.CIN    = cin;
  endtask

  initial begin
    ifr.CEP = 1'b1; ifr.CECARRYOUT = 1'b1;
    ifr.D = '0; ifr.A = '0; ifr.B = '0; ifr.PCIN = '0;
    set_ops(8'h0C, 48'h1234, 36'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: load 0x1234 via C, then async reset clears it before any edge
    cycle("t1_load");
    chk("t1_load_val", 64'(ifr.P), 64'h1234);
    do_reset("t1", 3);

    // 2: C + M
    set_ops(8'h0D, 48'd5, 36'd1000, 1'b0);
    #1;
    chk("t2_comb_same_cycle", 64'(ifc.P), 64'd1005);
    cycle("t2");
    chk("t2_p", 64'(ifr.P), 64'd1005);
    chk("t2_co", 64'(ifr.CARRYOUT), 64'd0);

    // 3: subtract, then borrow
    set_ops(8'h8D, 48'd10, 36'd3, 1'b1);
    cycle("t3a");
    chk("t3a_p", 64'(ifr.P), 64'd6);
    chk("t3a_co", 64'(ifr.CARRYOUT), 64'd0);
    set_ops(8'h8D, 48'd2, 36'd5, 1'b0);
    cycle("t3b");
    chk("t3b_p", 64'(ifr.P), 64'hFFFF_FFFF_FFFD);
    chk("t3b_co", 64'(ifr.CARRYOUT), 64'd1);

    // 4: accumulate M=7, hold with CEP low, restart after reset
    do_reset("t4", 1);
    set_ops(8'h09, 48'd0, 36'd7, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cycle("t4_acc");
      chk("t4_acc_val", 64'(ifr.P), 64'(7 * k));
    end
    ifr.CEP = 1'b0;
    repeat (2) begin
      cycle("t4_hold");
      chk("t4_hold_val", 64'(ifr.P), 64'd28);
    end
    ifr.CEP = 1'b1;
    do_reset("t4_mid", 1);
    cycle("t4_restart");
    chk("t4_restart_val", 64'(ifr.P), 64'd7);

    // 5: wrap to zero with carry, then carry hold with CECARRYOUT low
    set_ops(8'h0D, 48'hFFFF_FFFF_FFFF, 36'd1, 1'b0);
    cycle("t5");
    chk("t5_p", 64'(ifr.P), 64'd0);
    chk("t5_co", 64'(ifr.CARRYOUT), 64'd1);
    ifr.CECARRYOUT = 1'b0;
    set_ops(8'h0D, 48'd0, 36'd1, 1'b0);
    cycle("t5_hold");
    chk("t5_hold_co", 64'(ifr.CARRYOUT), 64'd1);
    ifr.CECARRYOUT = 1'b1;

    // 6: D:A:B concatenation plus PCIN
    ifr.D = 18'h00ABC; ifr.A = 18'h1; ifr.B = 18'h2; ifr.PCIN = 48'd1;
    set_ops(8'h07, 48'd0, 36'd0, 1'b0);
    e6 = {12'hABC, 18'h1, 18'h2} + 48'd1;
    cycle("t6");
    chk("t6_p", 64'(ifr.P), 64'(e6));
    chk("t6_pcout", 64'(ifr.PCOUT), 64'(e6));

    // Random operands, opmodes, enables and occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset("rnd", $urandom_range(0, 2));
      ifr.OPMODE     = 8'($urandom);
      ifr.M          = {4'($urandom), 32'($urandom)};
      ifr.D          = 18'($urandom);
      ifr.A          = 18'($urandom);
      ifr.B          = 18'($urandom);
      ifr.C          = {16'($urandom), 32'($urandom)};
      ifr.PCIN       = {16'($urandom), 32'($urandom)};
      ifr.CIN        = 1'($urandom);
      ifr.CEP        = ($urandom_range(0, 4) != 0);
      ifr.CECARRYOUT = ($urandom_range(0, 4) != 0);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
Post-adder/subtractor and accumulator stage of the DSP48A1 slice. It sits directly downstream of the M-register stage and the C/carry-in register stages. It consumes the registered or bypassed multiplier product, C, the D:A:B concatenation and PCIN. It selects X/Z operands per OPMODE, adds or subtracts, and drives the optional P and CARRYOUT registers. P feedback enables multiply-accumulate.

Parameters:
PREG, 1, 1 = P output registered; 0 = P output combinational from the adder.
CARRYOUTREG, 1, 1 = CARRYOUT registered; 0 = combinational.
P_WIDTH, 48, post-adder/P width (fixed at 48 for DSP48A1; parameter exists for the bench only).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset of the P and carry-out registers.
CEP  in  1  clock enable, P register.
CECARRYOUT  in  1  clock enable, carry-out register.
OPMODE  in  8  [1:0] X select, [3:2] Z select, [7] post-add/sub; [6:4] ignored here.
M  in  36  product from the M stage.
D  in  18  D operand; bits [11:0] are used in the concatenation.
A  in  18  A operand (A1 stage).
B  in  18  B operand (B1 stage).
C  in  48  C operand from the C stage.
PCIN  in  48  cascade input from the previous slice.
CIN  in  1  carry-in from the carry-in stage.
P  out  48  result.
PCOUT  out  48  cascade out, identical to P.
CARRYOUT  out  1  post-adder carry/borrow.
CARRYOUTF  out  1  fabric copy of CARRYOUT.

Behaviour:
- Reset: rst=1 clears p_q and co_q to 0 immediately, with no clock edge needed. This overrides CE. With PREG=1, P and PCOUT read 0 while rst is high. With CARRYOUTREG=1, CARRYOUT and CARRYOUTF read 0 while rst is high.
- X mux (OPMODE[1:0]):
  - 0: 0
  - 1: {12'b0, M} (M zero-extended)
  - 2: p_q
  - 3: {D[11:0], A, B}
- Z mux (OPMODE[3:2]):
  - 0: 0
  - 1: PCIN
  - 2: p_q
  - 3: C
- Feedback (X=2 or Z=2) always uses the internal register p_q, never the P port. There is therefore no combinational loop when PREG=0. p_q is clocked with CEP regardless of PREG.
- Arithmetic, 49-bit unsigned:
  - OPMODE[7]=0: sum = {1'b0,Z} + {1'b0,X} + CIN.
  - OPMODE[7]=1: sum = {1'b0,Z} - ({1'b0,X} + CIN).
  - post = sum[47:0]; cout = sum[48]. cout is the carry on add and the borrow on subtract.
  - Overflow wraps modulo 2^48 with no saturation.
- Registers:
  - posedge clk: if CEP, p_q <= post.
  - posedge clk: if CECARRYOUT, co_q <= cout.
  - CE low holds the current value.
- Output select:
  - P = PREG ? p_q : post.
  - CARRYOUT = CARRYOUTREG ? co_q : cout.
  - PCOUT = P; CARRYOUTF = CARRYOUT.
- Latency: 1 clk with PREG=1, 0 with PREG=0. CARRYOUT latency follows CARRYOUTREG independently.
- Accumulate (Z=2 or X=2): each CEP-enabled edge adds the selected operand to the previous p_q. The first result after reset starts from 0.
- Reset mid-accumulation: the accumulation restarts from 0 on the first edge after rst falls. No partial value survives.
- rst release coincident with a clk edge: that edge does not load. The first load occurs on the next edge.
- OPMODE and operands are sampled only at the clock edge when registered. There are no internal pipeline stages beyond p_q and co_q.

Decomposition:
- Shared package dsp48a1_pkg:
  - X_ZERO/X_M/X_P/X_DAB and Z_ZERO/Z_PCIN/Z_P/Z_C select constants.
  - Constant P_W=48.
  - OPMODE bit-index constants OPM_POSTSUB=7, OPM_X=1:0, OPM_Z=3:2.
- One sub-module, dsp_postadd_core: combinational X/Z muxing plus the 49-bit add/sub, producing post and cout.
- The top module holds p_q, co_q, the async reset and the PREG/CARRYOUTREG output muxes.

Test Plan:
1. PREG=1, CARRYOUTREG=1; load P=48'h1234 via C; assert rst between clock edges -> P=0 and CARRYOUT=0 immediately, before any edge; hold rst across 3 edges -> both stay 0.
2. OPMODE=8'h0D (Z=C, X=M, add), C=48'd5, M=36'd1000, CIN=0, CEP=1 -> P=48'd1005 one edge later, CARRYOUT=0; with PREG=0 the same values appear in the same cycle.
3. Subtract:
   - OPMODE=8'h8D, C=10, M=3, CIN=1 -> P=6, CARRYOUT=0.
   - Then C=2, M=5, CIN=0 -> P=48'hFFFF_FFFF_FFFD, CARRYOUT=1.
4. Accumulate: OPMODE=8'h09 (Z=P, X=M), M=7, after reset -> P=7,14,21,28 on 4 successive edges; drop CEP for 2 edges -> P holds 28; rst mid-run -> next result is 7.
5. Wrap: OPMODE=8'h0D, C=48'hFFFF_FFFF_FFFF, M=1, CIN=0 -> P=0, CARRYOUT=1; with CECARRYOUT=0 -> CARRYOUT keeps its prior value.
6. Concat/cascade: OPMODE=8'h07 (Z=PCIN, X=D:A:B), D=18'h00ABC, A=18'h1, B=18'h2, PCIN=48'd1 -> P = {12'hABC, 18'h1, 18'h2} + 1; PCOUT equals P every cycle.
